// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants, alu_op encodings and control bundle
//
// Imported by mips_main_decoder and if_id_decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mips_main_decoder.sv
// rtl/mips_main_decoder.sv - combinational main decoder: instruction word to control bundle
//
// Ports:
//   instr   in  32  instruction word
//   ctrl    out     control bundle (all zero for NOP and illegal words)
//   illegal out  1  unsupported opcode, or R-type with unsupported funct
module mips_main_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    // The all-zero word is the canonical NOP; its funct 0x00 is otherwise unsupported.
    if (instr != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT) begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_LW: begin
          ctrl.alu_src    = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.alu_op     = ALUOP_ADD;
        end
        OP_SW: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_BEQ: begin
          ctrl.branch = 1'b1;
          ctrl.alu_op = ALUOP_SUB;
        end
        OP_ADDI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_J: begin
          ctrl.jump = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/if_id_decode.sv
// rtl/if_id_decode.sv - IF/ID pipeline register with main decode, stall and flush
//
// Ports:
//   clk, reset (async, active-high)
//   instr_in, pc_plus4_in, if_valid     fetch-stage inputs
//   stall, flush                        hazard controls (flush wins over stall)
//   id_valid, pc_plus4_out              registered valid flag and PC+4
//   opcode, rs, rt, rd, shamt, funct    raw instruction fields
//   imm_ext, jump_target                sign-extended immediate, 26-bit jump target
//   reg_dst .. jump, alu_op             main control signals
//   illegal                             unsupported instruction held in ID
// Optional (IF_ID_STATS_EN): instr_count[15:0], illegal_count[7:0], saturating.
module if_id_decode
  import mips_pkg::*;
#(
  parameter int PC_W   = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [PC_W-1:0]   pc_plus4_in,
  input  logic              if_valid,
  input  logic              stall,
  input  logic              flush,
  output logic              id_valid,
  output logic [PC_W-1:0]   pc_plus4_out,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [25:0]       jump_target,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic [1:0]        alu_op,
  output logic              illegal
`ifdef IF_ID_STATS_EN
  ,
  output logic [15:0]       instr_count,
  output logic [7:0]        illegal_count
`endif
);

  ctrl_t             dec_ctrl;
  ctrl_t             next_ctrl;
  logic              dec_illegal;
  logic [4:0]        dest;
  logic              load;

  logic [DATA_W-1:0] instr_q;
  ctrl_t             ctrl_q;

  mips_main_decoder u_dec (
    .instr   (instr_in),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Writes to $0 are dropped here so later stages never see a write enable for it.
  always_comb begin
    next_ctrl = dec_ctrl;
    dest      = dec_ctrl.reg_dst ? instr_in[15:11] : instr_in[20:16];
    if (dest == 5'd0) next_ctrl.reg_write = 1'b0;
  end

  assign load = !flush && !stall && if_valid;

  // Bubbles clear the captured word too, so every field reads 0 while id_valid=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid     <= 1'b0;
      pc_plus4_out <= '0;
      instr_q      <= '0;
      ctrl_q       <= CTRL_NONE;
      illegal      <= 1'b0;
    end else if (flush || (!stall && !if_valid)) begin
      id_valid     <= 1'b0;
      pc_plus4_out <= '0;
      instr_q      <= '0;
      ctrl_q       <= CTRL_NONE;
      illegal      <= 1'b0;
    end else if (load) begin
      id_valid     <= 1'b1;
      pc_plus4_out <= pc_plus4_in;
      instr_q      <= instr_in;
      ctrl_q       <= next_ctrl;
      illegal      <= dec_illegal;
    end
  end

  assign opcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign shamt       = instr_q[10:6];
  assign funct       = instr_q[5:0];
  assign imm_ext     = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
  assign jump_target = instr_q[25:0];
  assign reg_dst     = ctrl_q.reg_dst;
  assign alu_src     = ctrl_q.alu_src;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign branch      = ctrl_q.branch;
  assign jump        = ctrl_q.jump;
  assign alu_op      = ctrl_q.alu_op;

`ifdef IF_ID_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count   <= '0;
      illegal_count <= '0;
    end else if (load) begin
      if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
      if (dec_illegal && illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_decode.sv
// tb/tb_if_id_decode.sv - scoreboard testbench for if_id_decode
module tb_if_id_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic [4:0]  pc_plus4_in;
  logic        if_valid, stall, flush;
  logic        id_valid;
  logic [4:0]  pc_plus4_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext;
  logic [25:0] jump_target;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump;
  logic [1:0]  alu_op;
  logic        illegal;
`ifdef IF_ID_STATS_EN
  logic [15:0] instr_count;
  logic [7:0]  illegal_count;
  int          m_ic, m_lc;
`endif

  always #5 clk = ~clk;

  if_id_decode #(.PC_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
    .if_valid(if_valid), .stall(stall), .flush(flush),
    .id_valid(id_valid), .pc_plus4_out(pc_plus4_out), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_ext(imm_ext), .jump_target(jump_target),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .alu_op(alu_op), .illegal(illegal)
`ifdef IF_ID_STATS_EN
    , .instr_count(instr_count), .illegal_count(illegal_count)
`endif
  );

  // ctl bits: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump alu_op[1:0]
  typedef struct packed {
    logic        v;
    logic [4:0]  pc;
    logic [31:0] ins;
    logic [9:0]  ctl;
    logic        ill;
  } exp_t;

  exp_t model;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t decode(input logic [31:0] w, input logic [4:0] pc);
    exp_t       e;
    logic [9:0] c;
    logic       ill;
    logic [4:0] dst;
    c   = '0;
    ill = 1'b0;
    case (w[31:26])
      6'h00: begin
        if (w == 32'h0) c = '0;
        else if (w[5:0] == 6'h20 || w[5:0] == 6'h22 || w[5:0] == 6'h24 ||
                 w[5:0] == 6'h25 || w[5:0] == 6'h2A) c = 10'b1001000010;
        else ill = 1'b1;
      end
      6'h23:   c = 10'b0111100000;
      6'h2B:   c = 10'b0100010000;
      6'h04:   c = 10'b0000001001;
      6'h08:   c = 10'b0101000000;
      6'h02:   c = 10'b0000000100;
      default: ill = 1'b1;
    endcase
    dst = c[9] ? w[15:11] : w[20:16];
    if (dst == 5'd0) c[6] = 1'b0;
    e.v   = 1'b1;
    e.pc  = pc;
    e.ins = w;
    e.ctl = c;
    e.ill = ill;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty got=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".id_valid"}, id_valid, e.v);
    check({tag, ".pc"}, pc_plus4_out, e.pc);
    check({tag, ".fields"}, {opcode, rs, rt, rd, shamt, funct},
          {e.ins[31:26], e.ins[25:21], e.ins[20:16], e.ins[15:11], e.ins[10:6], e.ins[5:0]});
    check({tag, ".imm_ext"}, imm_ext, {{16{e.ins[15]}}, e.ins[15:0]});
    check({tag, ".jump_target"}, jump_target, e.ins[25:0]);
    check({tag, ".ctl"}, {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                          branch, jump, alu_op}, e.ctl);
    check({tag, ".illegal"}, illegal, e.ill);
`ifdef IF_ID_STATS_EN
    check({tag, ".instr_count"}, instr_count, m_ic);
    check({tag, ".illegal_count"}, illegal_count, m_lc);
`endif
  endtask

  task automatic step(input string tag, input logic [31:0] w, input logic [4:0] pc,
                      input logic v, input logic st, input logic fl);
    instr_in    = w;
    pc_plus4_in = pc;
    if_valid    = v;
    stall       = st;
    flush       = fl;
    if (fl) model = '0;
    else if (!st) begin
      model = v ? decode(w, pc) : '0;
`ifdef IF_ID_STATS_EN
      if (v) begin
        if (m_ic < 65535) m_ic++;
        if (model.ill && m_lc < 255) m_lc++;
      end
`endif
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".id_valid"}, id_valid, 0);
    check({tag, ".pc"}, pc_plus4_out, 0);
    check({tag, ".fields"}, {opcode, rs, rt, rd, shamt, funct, jump_target}, 0);
    check({tag, ".imm_ext"}, imm_ext, 0);
    check({tag, ".ctl"}, {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                          branch, jump, alu_op, illegal}, 0);
`ifdef IF_ID_STATS_EN
    check({tag, ".counts"}, {instr_count, illegal_count}, 0);
`endif
  endtask

  logic [31:0] words[8] = '{32'h02324020, 32'h8C880004, 32'h1109FFFF, 32'hAC880004,
                            32'h20080005, 32'h08000003, 32'hFC000000, 32'h02324021};

  initial begin
    reset = 1'b1; instr_in = '0; pc_plus4_in = '0; if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    model = '0;
`ifdef IF_ID_STATS_EN
    m_ic = 0; m_lc = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    step("add", 32'h02324020, 5'd4, 1, 0, 0);
    check("add.rs", rs, 17); check("add.rt", rt, 18); check("add.rd", rd, 8);
    check("add.funct", funct, 32'h20); check("add.reg_write", reg_write, 1);
    check("add.alu_op", alu_op, 2'b10);

    step("lw", 32'h8C880004, 5'd8, 1, 0, 0);
    check("lw.imm", imm_ext, 32'h4); check("lw.mem_read", mem_read, 1);
    check("lw.mem_to_reg", mem_to_reg, 1);

    step("beq", 32'h1109FFFF, 5'd12, 1, 0, 0);
    check("beq.imm", imm_ext, 32'hFFFFFFFF); check("beq.branch", branch, 1);
    check("beq.alu_op", alu_op, 2'b01);

    step("add2", 32'h02324020, 5'd16, 1, 0, 0);
    step("stall1", 32'h8C880004, 5'd20, 1, 1, 0);
    step("stall2", 32'hAC880004, 5'd24, 1, 1, 0);
    step("stall3", 32'hFC000000, 5'd28, 0, 1, 0);
    check("stall.rd", rd, 8); check("stall.pc", pc_plus4_out, 16);
    step("stall_flush", 32'h08000003, 5'd28, 1, 1, 1);
    check("flush.id_valid", id_valid, 0);

    step("j", 32'h08000003, 5'd4, 1, 0, 0);
    step("sw", 32'hAC880004, 5'd8, 1, 0, 0);
    step("addi", 32'h20080005, 5'd12, 1, 0, 0);
    step("add_r0", 32'h02320020, 5'd16, 1, 0, 0);
    check("add_r0.reg_write", reg_write, 0);
    step("illegal_op", 32'hFC000000, 5'd20, 1, 0, 0);
    check("illegal_op.illegal", illegal, 1); check("illegal_op.id_valid", id_valid, 1);
    step("nop", 32'h00000000, 5'd24, 1, 0, 0);
    check("nop.illegal", illegal, 0); check("nop.id_valid", id_valid, 1);
    step("bad_funct", 32'h02324021, 5'd28, 1, 0, 0);
    step("lw_r0", 32'h8C800004, 5'd0, 1, 0, 0);
    step("bubble", 32'h02324020, 5'd4, 0, 0, 0);

    step("pre_reset", 32'h02324020, 5'd8, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    model = '0;
`ifdef IF_ID_STATS_EN
    m_ic = 0; m_lc = 0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 32'h02324020, 5'd12, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] k;
      k = 3'($urandom_range(0, 7));
      step("rand", words[k], 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_decode.md
Name: if_id_decode

Overview:
- Pipeline register and instruction decoder directly downstream of the instruction memory/PC stage.
- Captures the fetched 32-bit instruction and the PC+4 value, then presents decoded fields, the sign-extended immediate and the main control signals to the register-file/execute stage.
- Supports stall (hold) and flush (bubble) requests from hazard/branch logic.

Parameters:
- PC_W, 5: width of the PC+4 value, matching the 5-bit byte-addressed instruction memory.
- DATA_W, 32: instruction and immediate width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_in  in  32  instruction word from fetch stage
- pc_plus4_in  in  PC_W  PC+4 from fetch stage
- if_valid  in  1  fetch word is valid this cycle
- stall  in  1  hold current ID contents
- flush  in  1  replace ID contents with a bubble
- id_valid  out  1  ID stage holds a real instruction
- pc_plus4_out  out  PC_W  registered PC+4
- opcode  out  6  instr[31:26]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm_ext  out  32  sign-extended instr[15:0]
- jump_target  out  26  instr[25:0]
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump  out  1 each  main control signals
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct
- illegal  out  1  unsupported opcode or funct

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. While reset is high, every output is 0, including id_valid, illegal and all fields.
- Latency: all outputs are registered. An instruction captured at edge N appears on the outputs after edge N and stays until the next update.
- Priority per edge: reset > flush > stall > capture.
  - flush=1: bubble loaded. id_valid=0, all controls and illegal 0, fields 0. This applies even if stall=1.
  - stall=1 (no flush): every output holds its value, including id_valid.
  - Otherwise, if_valid=0: bubble loaded.
  - Otherwise, if_valid=1: the instruction is decoded and loaded with id_valid=1.
- Decode table (controls not listed are 0):
  - R-type (op 0x00), funct 0x20/0x22/0x24/0x25/0x2A: reg_dst=1, reg_write=1, alu_op=10.
  - lw (0x23): alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - sw (0x2B): alu_src=1, mem_write=1, alu_op=00.
  - beq (0x04): branch=1, alu_op=01.
  - addi (0x08): alu_src=1, reg_write=1, alu_op=00.
  - j (0x02): jump=1.
- NOP: the all-zero word is valid with all controls 0 and illegal=0.
- Illegal: any other opcode, or R-type with an unlisted funct. id_valid=1, illegal=1, all controls 0, raw fields still presented.
- Register $0 writes: reg_write is forced to 0 when the destination register is $0 (rd for reg_dst=1, rt otherwise).
- Field outputs are raw bit slices, presented for every valid instruction regardless of type.
- imm_ext replicates instr[15] into bits 31:16.
- Reset mid-stall or mid-flush: outputs go to 0 immediately (asynchronous). The first capture is at the first edge after reset deasserts.

Optional Feature:
- Macro: IF_ID_STATS_EN.
- When defined, two output ports are added, both reset to 0 and both saturating:
  - instr_count[15:0]: increments on each edge where a valid instruction is loaded.
  - illegal_count[7:0]: increments when that loaded instruction is illegal.
  - Stalled or flushed cycles do not count.
- When undefined, these ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT;
  - alu_op encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - a control-bundle struct typedef.
- Sub-module mips_main_decoder: combinational, takes the instruction word and produces the control bundle plus illegal. The top level owns the pipeline register, the stall/flush priority and the $0 write suppression.

Test Plan:
- Reset, then capture 0x02324020 with if_valid=1 -> next cycle: id_valid=1, rs=17, rt=18, rd=8, funct=0x20, reg_dst=1, reg_write=1, alu_op=10, illegal=0.
- Capture lw 0x8C880004, then beq 0x1109FFFF -> lw: rs=4, rt=8, imm_ext=0x00000004, mem_read=1, mem_to_reg=1. beq: rs=8, rt=9, imm_ext=0xFFFFFFFF, branch=1, alu_op=01.
- Capture add, then stall=1 for 3 cycles while instr_in changes -> outputs unchanged. Next, stall=1 with flush=1 -> id_valid=0, all controls 0.
- Capture 0x02320020 (add into $0) -> reg_write=0. Capture 0xFC000000 -> id_valid=1, illegal=1, controls 0. Capture 0x00000000 -> illegal=0, controls 0.
- Assert reset asynchronously between clock edges while id_valid=1 -> all outputs 0 before the next edge. After release, if_valid=0 keeps id_valid=0.
- With IF_ID_STATS_EN: load 5 valid words (1 illegal), 2 stalls, 1 flush -> instr_count=5, illegal_count=1.
